// File: rtl/simd_result_collector.sv
// Drain-side collector for the depthwise SIMD array: tracks tap windows, captures Result into a FIFO.
// Optional RESULT_RELU_EN clamps negative lanes to zero before the FIFO write.
module simd_result_collector #(
  parameter int unsigned NUM_PE         = 16,
  parameter int unsigned OUT_DATA_WIDTH = 32,
  parameter int unsigned FILTER_SIZE    = 9,
  parameter int unsigned RESULT_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned GROUP          = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               tap_valid,
  input  logic                               first_data,
  input  logic [NUM_PE*OUT_DATA_WIDTH-1:0]   Result,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NUM_PE*OUT_DATA_WIDTH-1:0]   out_data,
  output logic                               out_last,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic                               err_overflow,
  output logic                               err_short,
  output logic                               err_extra
);

  localparam int unsigned W    = NUM_PE * OUT_DATA_WIDTH;
  localparam int unsigned CW   = $clog2(FILTER_SIZE + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned GW   = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [CW-1:0] FsLast = CW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] FsVal  = CW'(FILTER_SIZE);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} win_e;

  win_e                  win_st;
  logic [CW-1:0]         tap_cnt_q, tap_cnt_d;
  logic                  launch, set_short, set_extra;
  logic [RESULT_LATENCY-1:0] tok_q, tok_d;
  logic                  capture;

  logic [W:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           cnt_q, cnt_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic                  full, push, pop, drop, grp_last;
  logic [W-1:0]          cap_data;
  logic [W:0]            head;
  logic                  err_overflow_q, err_short_q, err_extra_q;

  // Window tracking: the tap count is the state, decoded into Idle/Accum/Done.
  always_comb begin
    tap_cnt_d = tap_cnt_q;
    launch    = 1'b0;
    set_short = 1'b0;
    set_extra = 1'b0;
    if (tap_cnt_q == '0) begin
      win_st = StIdle;
    end else if (tap_cnt_q == FsVal) begin
      win_st = StDone;
    end else begin
      win_st = StAccum;
    end
    if (tap_valid) begin
      if (first_data) begin
        set_short = (win_st == StAccum);
        tap_cnt_d = CW'(1);
      end else if (win_st != StAccum) begin
        set_extra = 1'b1;
      end else begin
        tap_cnt_d = tap_cnt_q + CW'(1);
        launch    = (tap_cnt_q == FsLast);
      end
    end
  end

  // Capture token waits RESULT_LATENCY cycles for the accumulators to settle.
  always_comb begin
    tok_d[0] = launch;
    for (int i = 1; i < int'(RESULT_LATENCY); i++) begin
      tok_d[i] = tok_q[i-1];
    end
  end

  assign capture = tok_q[RESULT_LATENCY-1];

  always_comb begin
    cap_data = Result;
`ifdef RESULT_RELU_EN
    for (int l = 0; l < int'(NUM_PE); l++) begin
      if (Result[l*OUT_DATA_WIDTH + OUT_DATA_WIDTH - 1]) begin
        cap_data[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = '0;
      end
    end
`endif
  end

  assign out_valid = (cnt_q != '0);
  assign full      = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;
  assign grp_last  = (grp_q == GW'(GROUP - 1));

  always_comb begin
    cnt_d = cnt_q;
    grp_d = grp_q;
    if (push & ~pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop & ~push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
    if (push) begin
      grp_d = grp_last ? '0 : grp_q + GW'(1);
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_data   = out_valid ? head[W-1:0] : '0;
  assign out_last   = out_valid & head[W];
  assign fifo_count = cnt_q;

  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;
  assign err_extra    = err_extra_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_cnt_q      <= '0;
      tok_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      grp_q          <= '0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
      err_extra_q    <= 1'b0;
    end else begin
      tap_cnt_q      <= tap_cnt_d;
      tok_q          <= tok_d;
      cnt_q          <= cnt_d;
      grp_q          <= grp_d;
      err_overflow_q <= err_overflow_q | drop;
      err_short_q    <= err_short_q | set_short;
      err_extra_q    <= err_extra_q | set_extra;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked until a word is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {grp_last, cap_data};
    end
  end

endmodule

// File: tb/tb_simd_result_collector.sv
// Scoreboard bench for simd_result_collector: directed windows, monitor compares every popped word.
module tb_simd_result_collector;

  localparam int unsigned NUM_PE = 16;
  localparam int unsigned ODW    = 32;
  localparam int unsigned W      = NUM_PE * ODW;
  localparam int unsigned FS     = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tap_valid = 1'b0;
  logic          first_data = 1'b0;
  logic [W-1:0]  Result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [4:0]    fifo_count;
  logic          err_overflow, err_short, err_extra;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  int unsigned   n_pops = 0;
  int unsigned   exp_grp = 0;
  logic [W:0]    exp_q[$];

  simd_result_collector #(
    .NUM_PE(NUM_PE), .OUT_DATA_WIDTH(ODW), .FILTER_SIZE(FS),
    .RESULT_LATENCY(1), .FIFO_DEPTH(16), .GROUP(16)
  ) dut (
    .clk(clk), .reset(reset), .tap_valid(tap_valid), .first_data(first_data),
    .Result(Result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .fifo_count(fifo_count), .err_overflow(err_overflow),
    .err_short(err_short), .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int unsigned base);
    logic [W-1:0] v;
    for (int i = 0; i < int'(NUM_PE); i++) begin
      v[i*ODW +: ODW] = (32'(i) << 28) | 32'(base);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
`ifdef RESULT_RELU_EN
    for (int i = 0; i < int'(NUM_PE); i++) begin
      if (v[i*ODW + ODW - 1]) r[i*ODW +: ODW] = '0;
    end
`endif
    return r;
  endfunction

  task automatic tap(input logic fd);
    tap_valid  = 1'b1;
    first_data = fd;
    @(posedge clk); #1;
    tap_valid  = 1'b0;
    first_data = 1'b0;
  endtask

  // Result is switched on the second tap so the previous window's capture,
  // which lands on this window's first tap, still sees its own vector.
  task automatic window(input logic [W-1:0] vec, input bit expect_push);
    for (int i = 0; i < int'(FS); i++) begin
      if (i == 1) Result = vec;
      tap(i == 0);
    end
    if (expect_push) begin
      exp_q.push_back({(exp_grp == 15) ? 1'b1 : 1'b0, model(vec)});
      exp_grp = (exp_grp + 1) % 16;
    end
  endtask

  task automatic drain();
    int unsigned n;
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n = 0;
    while (out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {512'b0, out_valid}, '0);
    chk("queue_empty", (W+1)'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("rst_flags", (W+1)'({out_valid, out_last, fifo_count, err_overflow, err_short, err_extra}),
        '0);
    chk("rst_data", {1'b0, out_data}, '0);
    exp_q.delete();
    exp_grp = 0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %0h expected no word", {out_last, out_data});
      end else begin
        chk("pop_word", {out_last, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [W-1:0] v1;
    int unsigned  p0;

    #2 reset = 1'b0;
    #1;
    chk("init_flags", (W+1)'({out_valid, out_last, fifo_count, err_overflow, err_short, err_extra}),
        '0);
    chk("init_data", {1'b0, out_data}, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single window: latency and ReLU lane.
    v1 = mk(0);
    v1[0 +: 32]  = 32'h0000_002A;
    v1[96 +: 32] = 32'hFFFF_FFF0;
    window(v1, 1'b1);
    chk("t1_not_yet", (W+1)'({out_valid, fifo_count}), '0);
    @(posedge clk); #1;
    chk("t1_valid_cnt", (W+1)'({out_valid, out_last, fifo_count}), (W+1)'({1'b1, 1'b0, 5'd1}));
    chk("t1_lane0", (W+1)'(out_data[31:0]), (W+1)'(32'h2A));
`ifdef RESULT_RELU_EN
    chk("t1_lane3", (W+1)'(out_data[127:96]), '0);
`else
    chk("t1_lane3", (W+1)'(out_data[127:96]), (W+1)'(32'hFFFF_FFF0));
`endif
    drain();

    // 16 back-to-back windows streaming out.
    do_reset();
    out_ready = 1'b1;
    p0 = n_pops;
    for (int k = 0; k < 16; k++) window(mk(k + 1), 1'b1);
    drain();
    chk("t2_pops", (W+1)'(n_pops - p0), (W+1)'(16));
    chk("t2_errs", (W+1)'({err_overflow, err_short, err_extra}), '0);

    // 17 windows into a stalled FIFO.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) window(mk(k + 100), k < 16);
    @(posedge clk); #1;
    chk("t3_errs", (W+1)'({err_overflow, err_short, err_extra}), (W+1)'(3'b100));
    chk("t3_count", (W+1)'(fifo_count), (W+1)'(16));
    p0 = n_pops;
    drain();
    chk("t3_pops", (W+1)'(n_pops - p0), (W+1)'(16));

    // Window restarted on tap 5.
    do_reset();
    out_ready = 1'b1;
    p0 = n_pops;
    for (int i = 0; i < 5; i++) tap(i == 0);
    window(mk(200), 1'b1);
    drain();
    chk("t4_errs", (W+1)'({err_overflow, err_short, err_extra}), (W+1)'(3'b010));
    chk("t4_pops", (W+1)'(n_pops - p0), (W+1)'(1));

    // Tenth tap without first_data.
    do_reset();
    out_ready = 1'b1;
    p0 = n_pops;
    window(mk(300), 1'b1);
    tap(1'b0);
    drain();
    chk("t5_errs", (W+1)'({err_overflow, err_short, err_extra}), (W+1)'(3'b001));
    chk("t5_pops", (W+1)'(n_pops - p0), (W+1)'(1));

    // Reset mid-window with data buffered, then a tap lacking first_data.
    do_reset();
    out_ready = 1'b0;
    window(mk(400), 1'b1);
    for (int i = 0; i < 4; i++) tap(i == 0);
    chk("t6_buffered", (W+1)'(fifo_count), (W+1)'(1));
    do_reset();
    tap(1'b0);
    @(posedge clk); #1;
    chk("t6_errs", (W+1)'({err_overflow, err_short, err_extra}), (W+1)'(3'b001));
    chk("t6_count", (W+1)'({out_valid, fifo_count}), '0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
